data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-port arbiter and access sequencer in front of the 64-byte, byte-addressed, little-endian 64-bit-wide data memory. It shares the memory's single port between the pipeline MEM stage (port 0) and a debug/loader port (port 1). It serialises their requests through a fixed req/gnt/rvalid handshake. It also range-checks every access so the memory never sees an address whose 8-byte span exceeds the array.

## Interface
- `ADDR_W`, default 64: address width of both requester ports and the memory address output.
- `DATA_W`, default 64: data width; one access is always DATA_W/8 bytes.
- `MEM_BYTES`, default 64: memory size in bytes; sets the range-check limit.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `p0_req`, `p1_req` in 1: request; held with stable command fields until `gnt` is seen.
- `p0_we`, `p1_we` in 1: 1 = 8-byte store, 0 = 8-byte load.
- `p0_addr`, `p1_addr` in ADDR_W: byte address, unaligned allowed.
- `p0_wdata`, `p1_wdata` in DATA_W: store data.
- `p0_gnt`, `p1_gnt` out 1: one-cycle pulse; command accepted.
- `p0_rvalid`, `p1_rvalid` out 1: one-cycle completion pulse, for loads and stores.
- `p0_rdata`, `p1_rdata` out DATA_W: load data, valid with `rvalid`.
- `p0_err`, `p1_err` out 1: out-of-range flag, valid with `rvalid`.
- `mem_addr` out ADDR_W: to memory `Mem_Addr`.
- `mem_wdata` out DATA_W: to memory `Write_Data`.
- `mem_write` out 1: to memory `MemWrite`.
- `mem_read` out 1: to memory `MemRead`.
- `mem_rdata` in DATA_W: from memory `Read_Data`, combinational.

## Operation
- The FSM has three states: IDLE, ACCESS and RESP.
- **Arbitration** happens only in IDLE and RESP, on the sampled `p0_req`/`p1_req`.
  - If exactly one request is high, that port wins.
  - On a tie, the policy in Configuration applies.
- **Winner latch.** The winner's `we`, `addr` and `wdata` are latched, together with the winner id, and the FSM moves to ACCESS. With no request, IDLE stays in IDLE and RESP goes to IDLE.
- **ACCESS** (always exactly one cycle):
  - the winner's `gnt` is high;
  - `mem_addr` and `mem_wdata` carry the latched values;
  - `mem_write` = we & in_range & ~reset;
  - `mem_read` = ~we & in_range & ~reset.
- **End of ACCESS.**
  - A store commits in memory.
  - For a load, `mem_rdata` is registered into the winner's `rdata`; otherwise `rdata` is set to 0.
  - `err` is set to ~in_range.
  - The FSM moves to RESP.
- **RESP.** The winner's `rvalid` is high for one cycle. The other port's `rdata`, `rvalid` and `err` stay 0.
- **Range check:** in_range = (addr <= MEM_BYTES-8), compared over the full ADDR_W. With the defaults, addresses 0..56 are legal and 57 or above are errors. An error access issues no memory strobe, returns `rdata`=0 and `err`=1.
- **Idle outputs.** Outside ACCESS, `mem_addr`, `mem_wdata`, `mem_write` and `mem_read` are all 0.
- **Requester rules:**
  - hold `req` and the command until `gnt`;
  - in the cycle after `gnt`, either drop `req` or present the next command.
  - A `req` that is still high in RESP is treated as a new request.

## Timing
- `req` sampled in IDLE at cycle N → `gnt` in N+1 (ACCESS) → `rvalid`, `rdata`, `err` in N+2 (RESP).
- Back-to-back: a request sampled in RESP gets `gnt` in the next cycle. Sustained throughput is one access per 2 cycles.
- Store visibility: memory is updated at the rising edge that ends ACCESS. A load granted in the following ACCESS returns the new data.
- Reset:
  - the FSM goes to IDLE;
  - all `gnt`, `rvalid` and `err` go to 0;
  - all `rdata` go to 0;
  - all `mem_*` outputs go to 0;
  - the round-robin pointer is set to "last = port 1".
- Reset asserted during ACCESS:
  - the memory strobes are forced low that cycle, so no store commits;
  - no `rvalid` follows;
  - the aborted requester must re-issue.
- `req` deasserted before `gnt` (illegal) is ignored from the next arbitration point. The latched command still completes.

## Configuration
- `DATA_MEM_ARB_RR_EN` defined: round-robin tie-break. The port not served last wins. After reset, port 0 wins the first tie.
- `DATA_MEM_ARB_RR_EN` undefined: fixed priority, port 0 always wins ties. Port 1 is served only when `p0_req` is low at an arbitration point. The round-robin pointer is not built.

## Test plan
- Port 0 load at addr 8 (memory initialised with bytes 8..15 = 8..15) → `p0_gnt` at N+1, `p0_rvalid` at N+2 with `p0_rdata`=0x0F0E0D0C0B0A0908, `p0_err`=0.
- Port 1 store of 0x1122334455667788 to addr 16, then port 1 load from addr 16 → load returns 0x1122334455667788. Bytes 16..23 change and byte 24 still reads 24.
- Both `req` held high for 4 grants with the macro defined → grant order 0,1,0,1, each spaced 2 cycles. With the macro undefined → 0,0,0,0, with port 1 starved.
- Port 0 load at addr 60 → `mem_read` never asserts, `p0_rvalid`=1 with `p0_err`=1 and `p0_rdata`=0. Addr 56 → `err`=0.
- Port 0 store of 0xFF..FF to addr 0 with `reset` pulsed in its ACCESS cycle → no `rvalid`. A subsequent load at addr 0 returns 0x000000000000000A, and all outputs are 0 in the cycle after reset.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port req/gnt/rvalid arbiter and range-checked access sequencer for the data memory
// Build option: DATA_MEM_ARB_RR_EN selects round-robin tie-break; undefined gives fixed port-0 priority.
module data_mem_arbiter #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MEM_BYTES = 64
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Highest start address whose full access span still fits in the array.
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_BYTES - DATA_W / 8);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic                lat_id;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_err;

    logic                arb_any;
    logic                arb_id;
    logic                arb_we;
    logic [ADDR_W-1:0]   arb_addr;
    logic [DATA_W-1:0]   arb_wdata;
    logic                lat_load;
    logic                in_range;
    logic                in_access;
    logic                in_resp;

`ifdef DATA_MEM_ARB_RR_EN
    logic                last_id;
`endif

    // Arbitration: a lone requester wins; ties go to the configured policy.
    always_comb begin
        arb_any = p0_req | p1_req;
`ifdef DATA_MEM_ARB_RR_EN
        if (p0_req && p1_req) begin
            arb_id = ~last_id;
        end else begin
            arb_id = ~p0_req;
        end
`else
        arb_id = ~p0_req;
`endif
        arb_we    = arb_id ? p1_we    : p0_we;
        arb_addr  = arb_id ? p1_addr  : p0_addr;
        arb_wdata = arb_id ? p1_wdata : p0_wdata;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = arb_any ? ACCESS : IDLE;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = arb_any ? ACCESS : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign lat_load  = (state != ACCESS) && arb_any;
    assign in_range  = (lat_addr <= ADDR_LIMIT);
    assign in_access = (state == ACCESS);
    assign in_resp   = (state == RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (lat_load) begin
                lat_we    <= arb_we;
                lat_addr  <= arb_addr;
                lat_wdata <= arb_wdata;
                lat_id    <= arb_id;
            end
            // Stores and out-of-range accesses both return zero data.
            if (in_access) begin
                rsp_data <= (!lat_we && in_range) ? mem_rdata : '0;
                rsp_err  <= ~in_range;
            end
        end
    end

`ifdef DATA_MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            last_id <= 1'b1;
        end else if (lat_load) begin
            last_id <= arb_id;
        end
    end
`endif

    // Reset gates the strobes directly so an ACCESS cut short by reset never commits.
    always_comb begin
        mem_addr  = in_access ? lat_addr  : '0;
        mem_wdata = in_access ? lat_wdata : '0;
        mem_write = in_access &  lat_we & in_range & ~reset;
        mem_read  = in_access & ~lat_we & in_range & ~reset;
    end

    always_comb begin
        p0_gnt    = in_access & ~lat_id;
        p1_gnt    = in_access &  lat_id;
        p0_rvalid = in_resp & ~lat_id;
        p1_rvalid = in_resp &  lat_id;
        p0_rdata  = p0_rvalid ? rsp_data : '0;
        p1_rdata  = p1_rvalid ? rsp_data : '0;
        p0_err    = p0_rvalid & rsp_err;
        p1_err    = p1_rvalid & rsp_err;
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - randomized self-checking bench for data_mem_arbiter with a transaction-level reference
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [63:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [63:0] p0_rdata, p1_rdata;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read;

    logic [7:0]  mem     [0:63];
    logic [7:0]  ref_mem [0:63];
    logic [7:0]  bd_data [0:63];
    logic        bd_en = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    logic saw_mem_read = 1'b0;

    // Reference state: pending access and pending response, as seen by requesters.
    logic        m_acc = 1'b0, m_win = 1'b0, m_we = 1'b0;
    logic [63:0] m_addr = '0, m_wdata = '0;
    logic        m_rsp = 1'b0, m_rsp_id = 1'b0, m_rsp_err = 1'b0;
    logic [63:0] m_rsp_data = '0;
    logic        m_last = 1'b1;

    always #5 clk = ~clk;

    data_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_read(mem_read), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (bd_en) begin
            for (int k = 0; k < 64; k++) mem[k] <= bd_data[k];
        end else if (mem_write && mem_addr <= 64'd56) begin
            for (int k = 0; k < 8; k++) mem[int'(mem_addr[5:0]) + k] <= mem_wdata[8*k +: 8];
        end
    end

    always_comb begin
        mem_rdata = '0;
        if (mem_addr <= 64'd56)
            for (int k = 0; k < 8; k++) mem_rdata[8*k +: 8] = mem[int'(mem_addr[5:0]) + k];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic in_rng(input logic [63:0] a);
        return a <= 64'd56;
    endfunction

    function automatic logic [63:0] ref_load(input logic [63:0] a);
        logic [63:0] v = '0;
        for (int k = 0; k < 8; k++) v[8*k +: 8] = ref_mem[int'(a) + k];
        return v;
    endfunction

    task automatic model_edge();
        logic w;
        if (reset) begin
            m_acc = 1'b0; m_rsp = 1'b0; m_last = 1'b1;
        end else if (m_acc) begin
            m_rsp      = 1'b1;
            m_rsp_id   = m_win;
            m_rsp_err  = !in_rng(m_addr);
            m_rsp_data = (!m_we && in_rng(m_addr)) ? ref_load(m_addr) : 64'd0;
            if (m_we && in_rng(m_addr))
                for (int k = 0; k < 8; k++) ref_mem[int'(m_addr) + k] = m_wdata[8*k +: 8];
            m_acc = 1'b0;
        end else begin
            m_rsp = 1'b0;
            if (p0_req || p1_req) begin
                if (p0_req && p1_req) begin
`ifdef DATA_MEM_ARB_RR_EN
                    w = !m_last;
`else
                    w = 1'b0;
`endif
                end else begin
                    w = p1_req;
                end
                m_last  = w;
                m_acc   = 1'b1;
                m_win   = w;
                m_we    = w ? p1_we    : p0_we;
                m_addr  = w ? p1_addr  : p0_addr;
                m_wdata = w ? p1_wdata : p0_wdata;
            end
        end
    endtask

    task automatic compare_outputs();
        logic v0, v1;
        v0 = m_rsp && !m_rsp_id;
        v1 = m_rsp && m_rsp_id;
        if (mem_read === 1'b1) saw_mem_read = 1'b1;
        chk("p0_gnt", p0_gnt, m_acc && !m_win);
        chk("p1_gnt", p1_gnt, m_acc && m_win);
        chk("mem_addr", mem_addr, m_acc ? m_addr : 64'd0);
        chk("mem_wdata", mem_wdata, m_acc ? m_wdata : 64'd0);
        chk("mem_write", mem_write, m_acc && m_we && in_rng(m_addr) && !reset);
        chk("mem_read", mem_read, m_acc && !m_we && in_rng(m_addr) && !reset);
        chk("p0_rvalid", p0_rvalid, v0);
        chk("p0_rdata", p0_rdata, v0 ? m_rsp_data : 64'd0);
        chk("p0_err", p0_err, v0 && m_rsp_err);
        chk("p1_rvalid", p1_rvalid, v1);
        chk("p1_rdata", p1_rdata, v1 ? m_rsp_data : 64'd0);
        chk("p1_err", p1_err, v1 && m_rsp_err);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic mem_load();
        for (int k = 0; k < 64; k++) ref_mem[k] = bd_data[k];
        bd_en = 1'b1;
        step();
        bd_en = 1'b0;
    endtask

    task automatic set_cmd(input int p, input logic we, input logic [63:0] a, input logic [63:0] d);
        if (p == 0) begin p0_we = we; p0_addr = a; p0_wdata = d; p0_req = 1'b1; end
        else        begin p1_we = we; p1_addr = a; p1_wdata = d; p1_req = 1'b1; end
    endtask

    task automatic issue(input int p, input logic we, input logic [63:0] a, input logic [63:0] d,
                         output logic [63:0] rd, output logic er);
        int n = 0;
        set_cmd(p, we, a, d);
        do begin
            step();
            n++;
        end while (!((p == 0) ? p0_gnt : p1_gnt) && n < 8);
        chk("gnt_latency", 64'(n), 64'd1);
        if (p == 0) p0_req = 1'b0; else p1_req = 1'b0;
        step();
        chk("rvalid_latency", (p == 0) ? p0_rvalid : p1_rvalid, 64'd1);
        rd = (p == 0) ? p0_rdata : p1_rdata;
        er = (p == 0) ? p0_err : p1_err;
    endtask

    function automatic logic [63:0] rnd_addr();
        int s = $urandom_range(0, 99);
        if (s < 60) return 64'($urandom_range(0, 56));
        if (s < 80) return 64'($urandom_range(57, 63));
        if (s < 88) return 64'd56;
        if (s < 94) return 64'h0000_0001_0000_0008;
        return {$urandom, $urandom} | 64'h40;
    endfunction

    task automatic new_cmd(input int p);
        set_cmd(p, 1'($urandom_range(0, 1)), rnd_addr(), {$urandom, $urandom});
    endtask

    task automatic drive_random();
        if (p0_gnt) begin
            if ($urandom_range(0, 1) == 1) new_cmd(0); else p0_req = 1'b0;
        end else if (!p0_req && $urandom_range(0, 2) == 0) new_cmd(0);
        if (p1_gnt) begin
            if ($urandom_range(0, 1) == 1) new_cmd(1); else p1_req = 1'b0;
        end else if (!p1_req && $urandom_range(0, 2) == 0) new_cmd(1);
        reset = ($urandom_range(0, 199) == 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        logic        er;
        int gp[$];
        int gc[$];
        int exp_port[4];

        reset = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        for (int k = 0; k < 64; k++) bd_data[k] = 8'(k);
        repeat (2) step();
        reset = 1'b0;
        mem_load();

        issue(0, 1'b0, 64'd8, 64'd0, rd, er);
        chk("load8_data", rd, 64'h0F0E0D0C0B0A0908);
        chk("load8_err", er, 64'd0);

        issue(1, 1'b1, 64'd16, 64'h1122334455667788, rd, er);
        chk("store16_rdata", rd, 64'd0);
        chk("store16_err", er, 64'd0);
        issue(1, 1'b0, 64'd16, 64'd0, rd, er);
        chk("load16_data", rd, 64'h1122334455667788);
        issue(1, 1'b0, 64'd24, 64'd0, rd, er);
        chk("load24_data", rd, 64'h1F1E1D1C1B1A1918);

        reset = 1'b1; step(); reset = 1'b0; step();
        set_cmd(0, 1'b0, 64'd0, 64'd0);
        set_cmd(1, 1'b0, 64'd8, 64'd0);
        for (int c = 1; c <= 8; c++) begin
            step();
            if (p0_gnt) begin gp.push_back(0); gc.push_back(c); end
            if (p1_gnt) begin gp.push_back(1); gc.push_back(c); end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        step(); step();
`ifdef DATA_MEM_ARB_RR_EN
        exp_port = '{0, 1, 0, 1};
`else
        exp_port = '{0, 0, 0, 0};
`endif
        chk("tie_grant_count", 64'(gp.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < gp.size()) begin
                chk("tie_grant_port", 64'(gp[i]), 64'(exp_port[i]));
                if (i > 0) chk("tie_grant_spacing", 64'(gc[i] - gc[i-1]), 64'd2);
            end
        end

        saw_mem_read = 1'b0;
        issue(0, 1'b0, 64'd60, 64'd0, rd, er);
        chk("oor60_no_mem_read", saw_mem_read, 64'd0);
        chk("oor60_err", er, 64'd1);
        chk("oor60_rdata", rd, 64'd0);
        issue(0, 1'b0, 64'd56, 64'd0, rd, er);
        chk("edge56_err", er, 64'd0);
        chk("edge56_data", rd, 64'h3F3E3D3C3B3A3938);

        for (int k = 0; k < 64; k++) bd_data[k] = (k == 0) ? 8'h0A : ((k < 8) ? 8'h00 : 8'(k));
        mem_load();
        set_cmd(0, 1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        chk("abort_gnt", p0_gnt, 64'd1);
        reset = 1'b1;
        #1;
        chk("abort_mem_write", mem_write, 64'd0);
        step();
        reset = 1'b0;
        p0_req = 1'b0;
        step();
        chk("post_reset_gnt", p0_gnt, 64'd0);
        chk("post_reset_rvalid", p0_rvalid, 64'd0);
        chk("post_reset_mem_addr", mem_addr, 64'd0);
        issue(0, 1'b0, 64'd0, 64'd0, rd, er);
        chk("abort_load0", rd, 64'h000000000000000A);

        reset = 1'b1; step(); reset = 1'b0;
        for (int k = 0; k < 64; k++) bd_data[k] = 8'($urandom);
        mem_load();
        for (int c = 0; c < 3000; c++) begin
            step();
            drive_random();
        end
        p0_req = 1'b0; p1_req = 1'b0; reset = 1'b0;
        repeat (4) step();
        for (int k = 0; k < 64; k++) chk("final_mem_byte", 64'(mem[k]), 64'(ref_mem[k]));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
